// File: rtl/multdiv_unit.sv
// Iterative signed multiply / restoring divide unit for the execute stage.
// Latency: data_resultRDY pulses WIDTH+1 cycles after the start edge; one op in flight.
// Backpressure: none accepted; busy stalls the pipeline, a new start abandons any op in flight.
//
// Ports:
//   clk, clr                     clock (rising edge), async active-high reset
//   ctrl_MULT, ctrl_DIV          start strobes, sampled at posedge (multiply wins if both)
//   data_operandA/B              multiplicand/dividend, multiplier/divisor (latched at start)
//   data_result, data_exception  low product bits / quotient, overflow or divide-by-zero
//   data_resultRDY               one-cycle pulse when result/exception update
//   busy                         operation in progress
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_start, w_done;
  logic [CW-1:0]    r_cnt;
  // r_acc: product high half / partial remainder
  // r_lo : multiplier shifting out, product low half / dividend shifting out, quotient in
  // r_mb : multiplicand or divisor magnitude
  logic [WIDTH-1:0] r_acc, r_lo, r_mb;
  logic             r_neg, r_div, r_bzero;

  // Magnitudes as unsigned WIDTH bits: -2^(W-1) maps to 2^(W-1), which still fits.
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_mag_a = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign w_mag_b = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign busy    = (r_state != IDLE);

  // Shift-add step: conditionally add multiplicand to the high half, then shift
  // the {carry, high, low} pair right by one.
  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_mul_sum;
  assign w_addend  = r_lo[0] ? r_mb : '0;
  assign w_mul_sum = {1'b0, r_acc} + {1'b0, w_addend};

  // Restoring step: shift next dividend bit into the remainder and subtract if it fits.
  logic [WIDTH:0] w_div_shift, w_div_diff;
  logic           w_div_ge;
  assign w_div_shift = {r_acc, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mb});
  assign w_div_diff  = w_div_shift - {1'b0, r_mb};

  // Sign correction applied in FIX.
  logic [2*WIDTH-1:0] w_prod_mag, w_prod;
  logic [WIDTH:0]     w_prod_top;
  logic               w_mul_exc;
  logic [WIDTH-1:0]   w_quot;
  logic               w_div_exc;
  assign w_prod_mag = {r_acc, r_lo};
  assign w_prod     = r_neg ? -w_prod_mag : w_prod_mag;
  assign w_prod_top = w_prod[2*WIDTH-1:WIDTH-1];
  assign w_mul_exc  = ~((&w_prod_top) | ~(|w_prod_top));
  // A zero quotient stays positive; the only unsigned magnitude that cannot be
  // represented positively is 2^(W-1) (from -2^(W-1) / -1).
  assign w_quot     = (r_neg && (|r_lo)) ? -r_lo : r_lo;
  assign w_div_exc  = r_bzero | (~r_neg & r_lo[WIDTH-1]);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    if (w_start) begin
      // A start in any state, including FIX, replaces the op in flight.
      w_state_nxt = ctrl_MULT ? MUL : DIV;
    end else begin
      case (r_state)
        MUL, DIV: if (r_cnt == LAST) w_state_nxt = FIX;
        FIX: begin
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_cnt          <= '0;
      r_acc          <= '0;
      r_lo           <= '0;
      r_mb           <= '0;
      r_neg          <= 1'b0;
      r_div          <= 1'b0;
      r_bzero        <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= w_done;
      if (w_start) begin
        r_cnt   <= '0;
        r_acc   <= '0;
        r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        r_div   <= ~ctrl_MULT;
        r_bzero <= ~(|data_operandB);
        if (ctrl_MULT) begin
          r_lo <= w_mag_b;
          r_mb <= w_mag_a;
        end else begin
          r_lo <= w_mag_a;
          r_mb <= w_mag_b;
        end
      end else begin
        case (r_state)
          MUL: begin
            r_acc <= w_mul_sum[WIDTH:1];
            r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
          end
          DIV: begin
            r_acc <= w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0];
            r_lo  <= {r_lo[WIDTH-2:0], w_div_ge};
            r_cnt <= r_cnt + CW'(1);
          end
          FIX: begin
            if (r_div) begin
              data_result    <= r_bzero ? '0 : w_quot;
              data_exception <= w_div_exc;
            end else begin
              data_result    <= w_prod[WIDTH-1:0];
              data_exception <= w_mul_exc;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_unit.sv
// Self-checking bench for multdiv_unit: directed corner cases plus random ops,
// expected results from plain signed arithmetic queued into a scoreboard.
module tb_multdiv_unit;
  localparam int W = 32;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;
  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;

  logic          clk = 1'b0;
  logic          clr;
  logic          ctrl_MULT, ctrl_DIV;
  logic [W-1:0]  data_operandA, data_operandB;
  logic [W-1:0]  data_result;
  logic          data_exception, data_resultRDY, busy;

  multdiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          at;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: plain 64-bit signed arithmetic.
  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = 32'(p);
      e = (p < -64'sd2147483648) || (p > 64'sd2147483647);
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == INT_MIN && b == 32'hFFFF_FFFF) begin
      r = INT_MIN;
      e = 1'b1;
    end else begin
      p = longint'($signed(a)) / longint'($signed(b));
      r = 32'(p);
      e = 1'b0;
    end
  endfunction

  // Called at a negedge; drives a start for one cycle and returns at the negedge after E0.
  // If the op is expected to complete, its result and RDY cycle are queued.
  task automatic start_op(input bit mul, input bit both, input logic [31:0] a,
                          input logic [31:0] b, input bit expect_done);
    exp_t e;
    ctrl_MULT     = mul | both;
    ctrl_DIV      = ~mul | both;
    data_operandA = a;
    data_operandB = b;
    if (expect_done) begin
      model(mul | both, a, b, e.res, e.exc);
      e.at = cyc + 34;
      sb.push_back(e);
    end
    @(negedge clk);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return INT_MIN;
      4: return INT_MAX;
      5: return 32'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops the scoreboard on each RDY and checks outputs hold in between.
  logic [31:0] m_res;
  logic        m_exc;
  initial begin
    exp_t e;
    m_res = '0;
    m_exc = 1'b0;
    forever begin
      @(negedge clk or posedge clr);
      if (clr) begin
        m_res = '0;
        m_exc = 1'b0;
      end else if (data_resultRDY) begin
        if (sb.size() == 0) begin
          check("unexpected_rdy", 64'(data_result), 64'hDEAD);
        end else begin
          e = sb.pop_front();
          check("result", 64'(data_result), 64'(e.res));
          check("exception", 64'(data_exception), 64'(e.exc));
          check("rdy_cycle", 64'(cyc), 64'(e.at));
          m_res = e.res;
          m_exc = e.exc;
        end
      end else begin
        check("hold_result", 64'(data_result), 64'(m_res));
        check("hold_exception", 64'(data_exception), 64'(m_exc));
      end
    end
  end

  initial begin
    int k;
    bit mul;
    clr = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    @(negedge clk);
    check("reset_result", 64'(data_result), 64'd0);
    check("reset_exc", 64'(data_exception), 64'd0);
    check("reset_rdy", 64'(data_resultRDY), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    clr = 1'b0;
    wait_neg(2);

    // 1: latency and busy window
    start_op(1, 0, 32'd7, 32'hFFFF_FFFD, 1);
    check("busy_at_E0", 64'(busy), 64'd1);
    wait_neg(32);
    check("busy_at_E0+32", 64'(busy), 64'd1);
    wait_neg(1);
    check("busy_after_rdy", 64'(busy), 64'd0);

    // 2..4: overflow, INT_MIN operands, divide corners (back-to-back in RDY cycle)
    start_op(1, 0, 32'h0001_0000, 32'h0001_0000, 1); wait_neg(33);
    start_op(1, 0, INT_MIN, 32'd1, 1);               wait_neg(33);
    start_op(0, 0, 32'hFFFF_FFF9, 32'd2, 1);         wait_neg(33);
    start_op(0, 0, 32'd7, 32'd0, 1);                 wait_neg(33);
    start_op(0, 0, INT_MIN, 32'hFFFF_FFFF, 1);       wait_neg(33);
    start_op(0, 0, INT_MIN, 32'd2, 1);               wait_neg(35);

    // 5: clr mid-op clears outputs at once and aborts the op
    start_op(1, 0, 32'd5, 32'd6, 0);
    wait_neg(9);
    #2 clr = 1'b1;
    #1;
    check("clr_result", 64'(data_result), 64'd0);
    check("clr_exc", 64'(data_exception), 64'd0);
    check("clr_busy", 64'(busy), 64'd0);
    check("clr_rdy", 64'(data_resultRDY), 64'd0);
    #1 clr = 1'b0;
    wait_neg(40);
    start_op(1, 0, 32'd5, 32'd6, 1); wait_neg(34);

    // 6: restart while busy, and both strobes high
    start_op(1, 0, 32'd3, 32'd4, 0);
    wait_neg(11);
    start_op(0, 0, 32'd100, 32'd7, 1); wait_neg(34);
    start_op(0, 1, 32'd6, 32'd3, 1);   wait_neg(34);

    // random ops, some abandoned (including a restart in the final cycle)
    for (int i = 0; i < 40; i++) begin
      mul = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) begin
        start_op(mul, 0, pick(), pick(), 0);
        k = $urandom_range(0, 32);
        wait_neg(k);
      end
      start_op(mul, ($urandom_range(0, 5) == 0), pick(), pick(), 1);
      wait_neg(33 + $urandom_range(0, 3));
    end

    wait_neg(40);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
